// File: rtl/motor_pkg.sv
// motor_pkg: shared types for the H-bridge drive sequencer.
// Sequencer state encoding and bridge direction constants.
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    REVERSE,
    DEAD,
    BRAKE
  } motor_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;

  function automatic logic drives_leg(
    input motor_state_t s
  );
    return (s == RUN) || (s == REVERSE);
  endfunction

endpackage

// File: rtl/motor_drive_sequencer_pwm_timebase.sv
// pwm_timebase: prescale and period counters for one PWM channel.
// Flags the last cycle of each period and pulses period_start after it.
module pwm_timebase #(
  parameter int PRESCALE = 200,
  parameter int DUTY_MAX = 500,
  parameter int DUTY_W   = 10
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  output logic [DUTY_W-1:0] period_cnt,
  output logic              boundary,
  output logic              period_start
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST =
    PW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] PC_LAST =
    DUTY_W'(DUTY_MAX - 1);

  logic [PW-1:0] ps_cnt;
  logic          ps_wrap;
  logic          pc_last;

  assign ps_wrap  = (ps_cnt == PS_LAST);
  assign pc_last  = (period_cnt == PC_LAST);
  assign boundary = ps_wrap && pc_last;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt       <= '0;
      period_cnt   <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (ps_wrap) begin
        ps_cnt <= '0;
        if (pc_last) begin
          period_cnt <= '0;
        end else begin
          period_cnt <= period_cnt + DUTY_W'(1);
        end
      end else begin
        ps_cnt <= ps_cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer: one H-bridge channel with duty ramping,
// reversal through ramp-down plus coast dead-time, and braking.
module motor_drive_sequencer
  import motor_pkg::*;
#(
  parameter int PRESCALE     = 200,
  parameter int DUTY_MAX     = 500,
  parameter int DUTY_W       = 10,
  parameter int RAMP_STEP    = 25,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_brake,
  output logic              pwm_f,
  output logic              pwm_b,
  output logic [DUTY_W-1:0] cur_duty,
  output logic              cur_dir,
  output logic              busy,
  output logic              period_start
);

  localparam int DCW =
    (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
  localparam logic [DCW-1:0] DEAD_LOAD =
    DCW'(DEAD_PERIODS);
  localparam logic [DUTY_W-1:0] DMAX =
    DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] STEP =
    DUTY_W'(RAMP_STEP);

  motor_state_t      state;
  motor_state_t      state_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic              dir_nxt;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] target_nxt;
  logic              pend_dir;
  logic              pend_dir_nxt;
  logic [DUTY_W-1:0] pend_duty;
  logic [DUTY_W-1:0] pend_duty_nxt;
  logic [DCW-1:0]    dead_cnt;
  logic [DCW-1:0]    dead_nxt;

  logic [DUTY_W-1:0] period_cnt;
  logic              boundary;
  logic [DUTY_W-1:0] duty_c;
  logic [DUTY_W-1:0] gap;
  logic [DUTY_W-1:0] ramped;
  logic              going_up;
  logic              cmd_fire;
  logic              cmd_move;
  logic              leg_on;
  logic              brake_nxt;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .DUTY_MAX (DUTY_MAX),
    .DUTY_W   (DUTY_W)
  ) u_timebase (
    .clk_50MHz    (clk_50MHz),
    .rst_n        (rst_n),
    .period_cnt   (period_cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign cmd_ready =
    !((state == REVERSE) || (state == DEAD));
  assign busy = (cur_duty != target) ||
                (state == REVERSE) ||
                (state == DEAD);

  assign cmd_fire = cmd_valid && cmd_ready;
  assign cmd_move = !cmd_brake;
  assign duty_c   = (cmd_duty > DMAX) ? DMAX : cmd_duty;

  // One ramp step, clipped to the target so it never overshoots.
  assign going_up = (target > cur_duty);
  assign gap      = going_up ? (target - cur_duty)
                             : (cur_duty - target);
  assign ramped   = (gap <= STEP) ? target :
                    going_up ? (cur_duty + STEP)
                             : (cur_duty - STEP);

  always_comb begin
    state_nxt     = state;
    duty_nxt      = cur_duty;
    dir_nxt       = cur_dir;
    target_nxt    = target;
    pend_dir_nxt  = pend_dir;
    pend_duty_nxt = pend_duty;
    dead_nxt      = dead_cnt;

    unique case (state)
      RUN: begin
        if (boundary) begin
          duty_nxt = ramped;
          if ((ramped == '0) && (target == '0)) begin
            state_nxt = IDLE;
          end
        end
      end
      REVERSE: begin
        if (boundary) begin
          duty_nxt = ramped;
          if (ramped == '0) begin
            state_nxt = DEAD;
            dead_nxt  = DEAD_LOAD;
          end
        end
      end
      DEAD: begin
        if (dead_cnt == '0) begin
          duty_nxt   = '0;
          dir_nxt    = pend_dir;
          target_nxt = pend_duty;
          state_nxt  = (pend_duty == '0) ? IDLE : RUN;
        end else if (boundary) begin
          dead_nxt = dead_cnt - DCW'(1);
        end
      end
      default: ;
    endcase

    // Commands sit on top of the boundary ramp, which used the old target.
    if (cmd_fire) begin
      unique case (1'b1)
        cmd_brake: begin
          state_nxt  = BRAKE;
          duty_nxt   = '0;
          target_nxt = '0;
        end
        (cmd_move && (state == IDLE)): begin
          if (duty_c != '0) begin
            state_nxt  = RUN;
            dir_nxt    = cmd_dir;
            target_nxt = duty_c;
          end
        end
        (cmd_move && (state == RUN)): begin
          if (duty_c == '0) begin
            target_nxt = '0;
          end else if (cmd_dir == cur_dir) begin
            state_nxt  = RUN;
            target_nxt = duty_c;
          end else if (cur_duty != '0) begin
            state_nxt     = REVERSE;
            pend_dir_nxt  = cmd_dir;
            pend_duty_nxt = duty_c;
            target_nxt    = '0;
          end else begin
            state_nxt  = RUN;
            dir_nxt    = cmd_dir;
            duty_nxt   = '0;
            target_nxt = duty_c;
          end
        end
        (cmd_move && (state == BRAKE)): begin
          state_nxt     = DEAD;
          pend_dir_nxt  = cmd_dir;
          pend_duty_nxt = duty_c;
          dead_nxt      = DEAD_LOAD;
        end
        default: ;
      endcase
    end
  end

  // Gating on the next state lets brake entry and exit hit the pins
  // on the same edge as the state change.
  assign brake_nxt = (state_nxt == BRAKE);
  assign leg_on    = drives_leg(state_nxt) &&
                     (period_cnt < cur_duty);

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_duty  <= '0;
      cur_dir   <= DIR_FWD;
      target    <= '0;
      pend_dir  <= 1'b0;
      pend_duty <= '0;
      dead_cnt  <= '0;
      pwm_f     <= 1'b0;
      pwm_b     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_duty  <= duty_nxt;
      cur_dir   <= dir_nxt;
      target    <= target_nxt;
      pend_dir  <= pend_dir_nxt;
      pend_duty <= pend_duty_nxt;
      dead_cnt  <= dead_nxt;
      pwm_f     <= brake_nxt ||
                   (leg_on && (cur_dir == DIR_FWD));
      pwm_b     <= brake_nxt ||
                   (leg_on && (cur_dir == DIR_BWD));
    end
  end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer: table vectors plus a per-period duty
// scoreboard, with hand sequences for brake, boundary and reset.
module tb_motor_drive_sequencer;

  logic       clk_50MHz;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_duty;
  logic       cmd_brake;
  logic       pwm_f;
  logic       pwm_b;
  logic [3:0] cur_duty;
  logic       cur_dir;
  logic       busy;
  logic       period_start;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;
  logic brake_phase = 1'b0;

  logic [3:0] exp_q[$];

  typedef struct packed {
    logic        dir;
    logic [3:0]  duty;
    logic [7:0]  np;
    logic [47:0] seq;
    logic        exp_dir;
    logic        exp_ready;
    logic [7:0]  f_cnt;
    logic [7:0]  b_cnt;
  } vec_t;

  vec_t vecs[4];

  motor_drive_sequencer #(
    .PRESCALE     (2),
    .DUTY_MAX     (10),
    .DUTY_W       (4),
    .RAMP_STEP    (2),
    .DEAD_PERIODS (1)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dir      (cmd_dir),
    .cmd_duty     (cmd_duty),
    .cmd_brake    (cmd_brake),
    .pwm_f        (pwm_f),
    .pwm_b        (pwm_b),
    .cur_duty     (cur_duty),
    .cur_dir      (cur_dir),
    .busy         (busy),
    .period_start (period_start)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  always @(negedge clk_50MHz) begin
    if (rst_n && pwm_f && pwm_b && !brake_phase) begin
      overlap++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic wait_ps();
    int w = 0;
    do begin
      step();
      w++;
    end while (!period_start && w < 100);
    chk("period_start_seen", int'(period_start), 1);
  endtask

  task automatic send(input logic b,
                      input logic d,
                      input logic [3:0] du);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_brake = b;
    cmd_dir   = d;
    cmd_duty  = du;
    while (!cmd_ready && w < 200) begin
      step();
      w++;
    end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    cmd_brake = 1'b0;
  endtask

  task automatic drain();
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      wait_ps();
      e = exp_q.pop_front();
      chk("cur_duty", int'(cur_duty), int'(e));
    end
  endtask

  task automatic count_legs(output int f,
                            output int b);
    f = 0;
    b = 0;
    repeat (20) begin
      f += int'(pwm_f);
      b += int'(pwm_b);
      step();
    end
  endtask

  initial begin
    int f;
    int b;
    vecs[0] = '{dir: 1'b1, duty: 4'd6, np: 8'd4,
                seq: 48'h6642, exp_dir: 1'b1,
                exp_ready: 1'b1, f_cnt: 8'd12, b_cnt: 8'd0};
    vecs[1] = '{dir: 1'b0, duty: 4'd4, np: 8'd6,
                seq: 48'h420024, exp_dir: 1'b0,
                exp_ready: 1'b0, f_cnt: 8'd0, b_cnt: 8'd8};
    vecs[2] = '{dir: 1'b0, duty: 4'd15, np: 8'd4,
                seq: 48'hAA86, exp_dir: 1'b0,
                exp_ready: 1'b1, f_cnt: 8'd0, b_cnt: 8'd20};
    vecs[3] = '{dir: 1'b1, duty: 4'd8, np: 8'd10,
                seq: 48'h8642002468, exp_dir: 1'b1,
                exp_ready: 1'b0, f_cnt: 8'd16, b_cnt: 8'd0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_brake = 1'b0;
    cmd_dir   = 1'b0;
    cmd_duty  = 4'd0;
    repeat (3) step();
    chk("rst_pwm_f", int'(pwm_f), 0);
    chk("rst_pwm_b", int'(pwm_b), 0);
    chk("rst_cur_duty", int'(cur_duty), 0);
    chk("rst_cur_dir", int'(cur_dir), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_period_start", int'(period_start), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wait_ps();
      send(1'b0, vecs[i].dir, vecs[i].duty);
      chk("ready_after_cmd", int'(cmd_ready),
          int'(vecs[i].exp_ready));
      for (int k = 0; k < int'(vecs[i].np); k++) begin
        exp_q.push_back(vecs[i].seq[k*4 +: 4]);
      end
      drain();
      chk("cur_dir", int'(cur_dir), int'(vecs[i].exp_dir));
      count_legs(f, b);
      chk("pwm_f_high_cycles", f, int'(vecs[i].f_cnt));
      chk("pwm_b_high_cycles", b, int'(vecs[i].b_cnt));
    end

    // Brake while running forward at 8, then leave brake to fwd 4.
    brake_phase = 1'b1;
    wait_ps();
    send(1'b1, 1'b1, 4'd0);
    chk("brake_pwm_f", int'(pwm_f), 1);
    chk("brake_pwm_b", int'(pwm_b), 1);
    chk("brake_cur_duty", int'(cur_duty), 0);
    wait_ps();
    send(1'b0, 1'b1, 4'd4);
    brake_phase = 1'b0;
    chk("dead_cmd_ready", int'(cmd_ready), 0);
    chk("dead_busy", int'(busy), 1);
    chk("dead_pwm_f", int'(pwm_f), 0);
    chk("dead_pwm_b", int'(pwm_b), 0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd4);
    drain();

    // Command lands on the boundary cycle: that step keeps the old target.
    repeat (19) step();
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_duty  = 4'd8;
    chk("bnd_cmd_ready", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    chk("bnd_period_start", int'(period_start), 1);
    chk("bnd_old_target_step", int'(cur_duty), 4);
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd8);
    drain();

    // Reset pulsed in the middle of a ramp-down.
    wait_ps();
    send(1'b0, 1'b1, 4'd2);
    repeat (25) step();
    chk("pre_rst_duty", int'(cur_duty), 6);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_pwm_f", int'(pwm_f), 0);
    chk("mid_rst_pwm_b", int'(pwm_b), 0);
    chk("mid_rst_cur_duty", int'(cur_duty), 0);
    chk("mid_rst_cur_dir", int'(cur_dir), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_period_start", int'(period_start), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
    repeat (3) step();
    #3 rst_n = 1'b1;

    wait_ps();
    send(1'b0, 1'b1, 4'd4);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd4);
    drain();

    // Duty 0 ramps down and drops back to IDLE.
    wait_ps();
    send(1'b0, 1'b1, 4'd0);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    drain();
    chk("idle_busy", int'(busy), 0);
    chk("idle_cmd_ready", int'(cmd_ready), 1);
    count_legs(f, b);
    chk("idle_pwm_f_cycles", f, 0);
    chk("idle_pwm_b_cycles", b, 0);

    chk("legs_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
